// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: operation codes, opcode/funct maps, word layouts and encoder FSM states.
package mips_isa_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_AND   = 4'd1,
    OP_MULTU = 4'd2,
    OP_OR    = 4'd3,
    OP_SLL   = 4'd4,
    OP_SRA   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SUB   = 4'd7,
    OP_XOR   = 4'd8,
    OP_ADDI  = 4'd9,
    OP_ANDI  = 4'd10,
    OP_ORI   = 4'd11,
    OP_XORI  = 4'd12,
    OP_SW    = 4'd13,
    OP_LW    = 4'd14
  } op_e;

  // Primary opcodes, identical to the decoder's map
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_LW    = 6'b100011;

  // R-type funct field values
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_XOR   = 6'b100110;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } itype_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_field_encode.sv
// Combinational op + fields -> 32-bit MIPS word; flags codes with no encoding.
module instr_field_encode
  import mips_isa_pkg::*;
(
  input  op_e          op,
  input  logic [4:0]   rs,
  input  logic [4:0]   rt,
  input  logic [4:0]   rd,
  input  logic [4:0]   shamt,
  input  logic [15:0]  imm,
  output logic [WORD_W-1:0] word,
  output logic         illegal
);

  rtype_t rtype;
  itype_t itype;
  logic   is_r;

  always_comb begin
    illegal      = 1'b0;
    is_r         = 1'b1;
    rtype        = '0;
    rtype.opcode = OPC_RTYPE;
    rtype.rs     = rs;
    rtype.rt     = rt;
    rtype.rd     = rd;
    itype        = '0;
    itype.rs     = rs;
    itype.rt     = rt;
    itype.imm    = imm;
    // Shifts take shamt and zero rs; all other R-types keep shamt at zero
    case (op)
      OP_ADD:   rtype.funct = FN_ADD;
      OP_AND:   rtype.funct = FN_AND;
      OP_MULTU: begin rtype.funct = FN_MULTU; rtype.rd = '0; end
      OP_OR:    rtype.funct = FN_OR;
      OP_SLL:   begin rtype.funct = FN_SLL; rtype.rs = '0; rtype.shamt = shamt; end
      OP_SRA:   begin rtype.funct = FN_SRA; rtype.rs = '0; rtype.shamt = shamt; end
      OP_SRL:   begin rtype.funct = FN_SRL; rtype.rs = '0; rtype.shamt = shamt; end
      OP_SUB:   rtype.funct = FN_SUB;
      OP_XOR:   rtype.funct = FN_XOR;
      OP_ADDI:  begin is_r = 1'b0; itype.opcode = OPC_ADDI; end
      OP_ANDI:  begin is_r = 1'b0; itype.opcode = OPC_ANDI; end
      OP_ORI:   begin is_r = 1'b0; itype.opcode = OPC_ORI;  end
      OP_XORI:  begin is_r = 1'b0; itype.opcode = OPC_XORI; end
      OP_SW:    begin is_r = 1'b0; itype.opcode = OPC_SW;   end
      OP_LW:    begin is_r = 1'b0; itype.opcode = OPC_LW;   end
      default:  illegal = 1'b1;
    endcase
    word = illegal ? '0 : (is_r ? WORD_W'(rtype) : WORD_W'(itype));
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams symbolic ops into encoded MIPS words written sequentially to instruction memory.
// Optional INSTR_CHECKSUM_EN adds a running XOR of all written words.
module instr_stream_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 256,
  localparam int unsigned      CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op,
  input  logic              op_last,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [CNT_W-1:0]  word_count,
  output logic              done,
  output logic              err
`ifdef INSTR_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  state_e              state_q, state_d;
  logic                out_valid_q;
  logic [WORD_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [CNT_W-1:0]    issued_q;
  logic [CNT_W-1:0]    count_q;
  logic                err_q;
  logic                done_q;

  logic [WORD_W-1:0]   enc_word;
  logic                enc_illegal;
  logic                wr_done, op_fire, start_fire, full, load_word;

  instr_field_encode u_field_encode (
    .op      (op_e'(op)),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .imm     (imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign wr_done    = out_valid_q & imem_ready;
  assign op_ready   = (state_q == ST_LOAD) & (~out_valid_q | imem_ready);
  assign op_fire    = op_valid & op_ready;
  assign start_fire = start & (state_q == ST_IDLE);
  // issued_q counts words committed to the output register, so it is also the next word index
  assign full       = (issued_q == CNT_W'(DEPTH));
  assign load_word  = op_fire & ~enc_illegal & ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  if (op_fire && op_last) state_d = ST_FLUSH;
      ST_FLUSH: if (!out_valid_q || imem_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Single-entry output register; reloads in the same cycle its word drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      issued_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_d == ST_DONE);
      if (start_fire) begin
        issued_q <= '0;
        count_q  <= '0;
        err_q    <= 1'b0;
      end
      if (load_word) begin
        out_valid_q <= 1'b1;
        out_data_q  <= enc_word;
        out_addr_q  <= BASE_ADDR + ADDR_W'({issued_q, 2'b00});
        issued_q    <= issued_q + CNT_W'(1);
      end else if (wr_done) begin
        out_valid_q <= 1'b0;
      end
      if (wr_done && (count_q != CNT_W'(DEPTH))) count_q <= count_q + CNT_W'(1);
      if (op_fire && (enc_illegal || full)) err_q <= 1'b1;
    end
  end

  assign imem_we    = out_valid_q;
  assign imem_addr  = out_addr_q;
  assign imem_wdata = out_data_q;
  assign word_count = count_q;
  assign err        = err_q;
  assign done       = done_q;

`ifdef INSTR_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q;

  // Only writes change it, so it naturally holds from DONE until the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          csum_q <= '0;
    else if (start_fire) csum_q <= '0;
    else if (wr_done)    csum_q <= csum_q ^ out_data_q;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: expected writes queued at op acceptance, checked at memory handshake.
module tb_instr_stream_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [3:0] K_ADD = 4'd0, K_AND = 4'd1, K_MULTU = 4'd2, K_OR = 4'd3;
  localparam logic [3:0] K_SLL = 4'd4, K_SRA = 4'd5, K_SRL = 4'd6, K_SUB = 4'd7;
  localparam logic [3:0] K_XOR = 4'd8, K_ADDI = 4'd9, K_ANDI = 4'd10, K_ORI = 4'd11;
  localparam logic [3:0] K_XORI = 4'd12, K_SW = 4'd13, K_LW = 4'd14, K_BAD = 4'd15;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, op_valid, op_ready, op_last;
  logic [3:0]       op;
  logic [4:0]       rs, rt, rd, shamt;
  logic [15:0]      imm;
  logic             imem_we;
  logic             imem_ready = 1'b1;
  logic [31:0]      imem_addr, imem_wdata;
  logic [CNT_W-1:0] word_count;
  logic             done, err;
`ifdef INSTR_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   stall_lo = 0;
  int   stall_hi = 0;
  int   total_writes = 0;
  int   sess_base = 0;
  int   issued = 0;
  logic exp_err = 1'b0;
  logic [31:0] exp_csum = '0;
  wr_t  exp_q[$];
  wr_t  wr_log[$];

  instr_stream_encoder #(
    .ADDR_W    (32),
    .BASE_ADDR (32'h0),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .op_last    (op_last),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_count (word_count),
    .done       (done),
    .err        (err)
`ifdef INSTR_CHECKSUM_EN
   ,.checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory-side backpressure: ready drops for cycles in [stall_lo, stall_hi)
  always @(posedge clk) begin
    cyc++;
    #1 imem_ready = !(cyc >= stall_lo && cyc < stall_hi);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_enc(input logic [3:0] o, input logic [4:0] s, t, d, sh,
                                            input logic [15:0] im);
    case (o)
      K_ADD:   return {6'b000000, s, t, d, 5'd0, 6'b100000};
      K_AND:   return {6'b000000, s, t, d, 5'd0, 6'b100100};
      K_MULTU: return {6'b000000, s, t, 5'd0, 5'd0, 6'b011001};
      K_OR:    return {6'b000000, s, t, d, 5'd0, 6'b100101};
      K_SLL:   return {6'b000000, 5'd0, t, d, sh, 6'b000000};
      K_SRA:   return {6'b000000, 5'd0, t, d, sh, 6'b000011};
      K_SRL:   return {6'b000000, 5'd0, t, d, sh, 6'b000010};
      K_SUB:   return {6'b000000, s, t, d, 5'd0, 6'b100010};
      K_XOR:   return {6'b000000, s, t, d, 5'd0, 6'b100110};
      K_ADDI:  return {6'b001000, s, t, im};
      K_ANDI:  return {6'b001100, s, t, im};
      K_ORI:   return {6'b001101, s, t, im};
      K_XORI:  return {6'b001110, s, t, im};
      K_SW:    return {6'b101011, s, t, im};
      K_LW:    return {6'b100011, s, t, im};
      default: return 32'h0;
    endcase
  endfunction

  // Write-port monitor: scoreboard pop, stall stability and stall backpressure
  always @(negedge clk) begin : mon
    logic        held_v;
    logic [31:0] held_a, held_d;
    wr_t         e;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_we", 32'(imem_we), 32'd1);
        check("hold_addr", imem_addr, held_a);
        check("hold_data", imem_wdata, held_d);
      end
      held_v = 1'b0;
      if (imem_we) begin
        if (imem_ready) begin
          wr_log.push_back({imem_addr, imem_wdata});
          total_writes++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", imem_wdata, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", imem_addr, e.addr);
            check("wr_data", imem_wdata, e.data);
          end
        end else begin
          check("stall_op_ready", 32'(op_ready), 32'd0);
          held_v = 1'b1;
          held_a = imem_addr;
          held_d = imem_wdata;
        end
      end
    end
  end

  // All tasks enter and leave 1 time unit after a rising edge
  task automatic start_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    issued = 0;
    exp_err = 1'b0;
    exp_csum = '0;
    sess_base = total_writes;
    check("start_err_clr", 32'(err), 32'd0);
    check("start_wc_clr", 32'(word_count), 32'd0);
  endtask

  task automatic send_op(input logic [3:0] o, input logic [4:0] s, t, d, sh,
                         input logic [15:0] im, input logic last);
    int n = 0;
    logic [31:0] w;
    op = o; rs = s; rt = t; rd = d; shamt = sh; imm = im; op_last = last;
    op_valid = 1'b1;
    @(negedge clk);
    while (!op_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!op_ready) begin
      check("accept_timeout", 32'(op_ready), 32'd1);
      @(posedge clk); #1;
      op_valid = 1'b0;
      return;
    end
    if (o != K_BAD && issued < DEPTH) begin
      w = model_enc(o, s, t, d, sh, im);
      exp_q.push_back({32'(issued * 4), w});
      exp_csum ^= w;
      issued++;
    end else begin
      exp_err = 1'b1;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_last = 1'b0;
  endtask

  task automatic end_session(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_wc"}, 32'(word_count), 32'(issued));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_nwrites"}, 32'(total_writes - sess_base), 32'(issued));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
`ifdef INSTR_CHECKSUM_EN
    check({tag, "_csum"}, checksum, exp_csum);
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int b;
    rst_n = 1'b0; start = 1'b0; op_valid = 1'b0; op_last = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Single ADDI
    start_session();
    b = sess_base;
    send_op(K_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 1'b1);
    end_session("s1");
    check("s1_addr", wr_log[b].addr, 32'h0);
    check("s1_data", wr_log[b].data, 32'h2022_0005);

    // ADD / SLL / LW with a 3-cycle memory stall after the first op
    start_session();
    b = sess_base;
    send_op(K_ADD, 5'd4, 5'd5, 5'd4, 5'd3, 16'hFFFF, 1'b0);
    stall_lo = cyc + 1;
    stall_hi = cyc + 4;
    send_op(K_SLL, 5'd7, 5'd2, 5'd6, 5'd4, 16'h1234, 1'b0);
    send_op(K_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 1'b1);
    end_session("s2");
    check("s2_data0", wr_log[b].data, 32'h0085_2020);
    check("s2_data1", wr_log[b + 1].data, 32'h0002_3100);
    check("s2_data2", wr_log[b + 2].data, 32'h8FA8_0010);
    check("s2_addr2", wr_log[b + 2].addr, 32'h8);

    // Illegal op mid-stream, plus a Start pulse that must be ignored in LOAD
    start_session();
    b = sess_base;
    send_op(K_MULTU, 5'd1, 5'd2, 5'd9, 5'd7, 16'h0, 1'b0);
    send_op(K_BAD, 5'd3, 5'd3, 5'd3, 5'd3, 16'h0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("s3_err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1;
    send_op(K_SRA, 5'd3, 5'd4, 5'd5, 5'd31, 16'h0, 1'b0);
    send_op(K_SW, 5'd5, 5'd6, 5'd0, 5'd0, 16'hFFFC, 1'b1);
    end_session("s3");
    check("s3_addr0", wr_log[b].addr, 32'h0);
    check("s3_addr1", wr_log[b + 1].addr, 32'h4);
    check("s3_addr2", wr_log[b + 2].addr, 32'h8);

    // Overflow: six legal ops into a DEPTH=4 session
    start_session();
    send_op(K_AND, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b0);
    send_op(K_OR, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b0);
    send_op(K_XOR, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b0);
    send_op(K_ANDI, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b0);
    send_op(K_ORI, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b0);
    send_op(K_SUB, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b1);
    end_session("s4");

    // Reset while a word is stalled on the write port
    start_session();
    stall_lo = cyc + 1;
    stall_hi = cyc + 1000;
    send_op(K_XORI, 5'd9, 5'd10, 5'd0, 5'd0, 16'hA5A5, 1'b0);
    @(negedge clk);
    check("pre_rst_we", 32'(imem_we), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_op_ready", 32'(op_ready), 32'd0);
    check("midrst_wc", 32'(word_count), 32'd0);
    exp_q.delete();
    stall_hi = cyc;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_op_ready", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    start_session();
    b = sess_base;
    send_op(K_SRL, 5'd1, 5'd12, 5'd13, 5'd9, 16'h0, 1'b1);
    end_session("s5");
    check("s5_addr", wr_log[b].addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
